// File: rtl/cr_tlvp_axis_egress_pkg.sv
// Shared types for the TLV parser egress stage: the AXI4-Stream datapath
// word exchanged with the parser and a helper for skid-buffer slot selection.
package cr_tlvp_axis_egress_pkg;

  localparam int TDATA_W       = 64;
  localparam int TSTRB_W       = TDATA_W / 8;
  localparam int TID_W         = 8;
  localparam int TUSER_W       = 8;
  localparam int EGR_CNT_WIDTH = 32;

  // AXI4-Stream datapath word used on both the parser FIFO port and the egress.
  typedef struct packed {
    logic               tvalid;
    logic               tlast;
    logic [TID_W-1:0]   tid;
    logic [TSTRB_W-1:0] tstrb;
    logic [TUSER_W-1:0] tuser;
    logic [TDATA_W-1:0] tdata;
  } axi4s_dp_bus_t;

  typedef logic [1:0] occ_t;

  // Slot that receives the next push: (head + occ) mod 2.
  function automatic logic skid_wr_slot(input logic head, input occ_t occ);
    return head ^ occ[0];
  endfunction

endpackage

// File: rtl/cr_tlvp_axis_egress_skid2.sv
// Generic 2-entry skid buffer: FIFO-style push on one side, valid/ready on
// the other. The caller must only push when occ != 2.
module cr_tlvp_skid2
  import cr_tlvp_axis_egress_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output occ_t occ
);

  T     slot0;
  T     slot1;
  logic head;
  logic pop;
  logic wr_slot;
  occ_t occ_nxt;

  assign pop       = (occ != 2'd0) && out_ready;
  assign wr_slot   = skid_wr_slot(head, occ);
  assign out_valid = (occ != 2'd0);
  assign out_data  = head ? slot1 : slot0;

  // Occupancy bookkeeping: a simultaneous push and pop cancel out.
  always_comb begin
    occ_nxt = occ;
    unique case ({push, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // Slot storage, head pointer and occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      head  <= 1'b0;
      occ   <= 2'd0;
    end else begin
      if (push && !wr_slot) slot0 <= in_data;
      if (push &&  wr_slot) slot1 <= in_data;
      if (pop) head <= ~head;
      occ <= occ_nxt;
    end
  end

endmodule

// File: rtl/cr_tlvp_axis_egress.sv
// Egress stage after the TLV parser outbound FIFO: pops parser words into a
// 2-entry skid buffer, presents them as an AXI4-Stream master and keeps
// frame/beat statistics.
module cr_tlvp_axis_egress
  import cr_tlvp_axis_egress_pkg::*;
#(
  parameter int CNT_WIDTH = EGR_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tlvp_ob_empty,
  input  logic                 tlvp_ob_aempty,
  input  axi4s_dp_bus_t        tlvp_ob,
  output logic                 tlvp_ob_rd,
  input  logic                 egress_en,
  output axi4s_dp_bus_t        m_axis,
  input  logic                 m_axis_tready,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic                 egress_busy
);

  occ_t          occ;
  logic          buf_valid;
  logic          accept;
  logic          in_frame;
  axi4s_dp_bus_t wr_word;
  axi4s_dp_bus_t head_word;
  logic          unused_aempty;

  // Almost-empty carries no information this stage needs.
  assign unused_aempty = tlvp_ob_aempty;

  // Pop only from registered occupancy, so there is no path from tready.
  assign tlvp_ob_rd = !tlvp_ob_empty && egress_en && (occ != 2'd2);

  // The parser's tvalid field is meaningless under first-word fall-through.
  always_comb begin
    wr_word        = tlvp_ob;
    wr_word.tvalid = 1'b0;
  end

  cr_tlvp_skid2 #(
    .T (axi4s_dp_bus_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tlvp_ob_rd),
    .in_data   (wr_word),
    .out_valid (buf_valid),
    .out_ready (m_axis_tready),
    .out_data  (head_word),
    .occ       (occ)
  );

  // Present the head slot; tvalid reflects buffer occupancy.
  always_comb begin
    m_axis        = head_word;
    m_axis.tvalid = buf_valid;
  end

  assign accept      = buf_valid && m_axis_tready;
  assign egress_busy = buf_valid || in_frame;

  // Frame tracking and wrapping statistics on every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame  <= 1'b0;
      frame_cnt <= '0;
      beat_cnt  <= '0;
    end else if (accept) begin
      in_frame <= !head_word.tlast;
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      if (head_word.tlast) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cr_tlvp_axis_egress.sv
module tb_cr_tlvp_axis_egress;
  import cr_tlvp_axis_egress_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          tlvp_ob_empty;
  logic          tlvp_ob_aempty;
  axi4s_dp_bus_t tlvp_ob;
  logic          egress_en;
  logic          m_axis_tready;

  axi4s_dp_bus_t m_axis, m_axis4;
  logic          tlvp_ob_rd, tlvp_ob_rd4;
  logic          egress_busy, egress_busy4;
  logic [31:0]   frame_cnt, beat_cnt;
  logic [3:0]    frame_cnt4, beat_cnt4;

  int total = 0;
  int bad   = 0;

  axi4s_dp_bus_t src_q[$];
  axi4s_dp_bus_t exp_q[$];
  int cyc, pops, accepts, first_pop, first_acc, last_acc, gaps, drops;

  cr_tlvp_axis_egress #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .tlvp_ob_empty(tlvp_ob_empty),
    .tlvp_ob_aempty(tlvp_ob_aempty), .tlvp_ob(tlvp_ob), .tlvp_ob_rd(tlvp_ob_rd),
    .egress_en(egress_en), .m_axis(m_axis), .m_axis_tready(m_axis_tready),
    .frame_cnt(frame_cnt), .beat_cnt(beat_cnt), .egress_busy(egress_busy)
  );

  cr_tlvp_axis_egress #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tlvp_ob_empty(tlvp_ob_empty),
    .tlvp_ob_aempty(tlvp_ob_aempty), .tlvp_ob(tlvp_ob), .tlvp_ob_rd(tlvp_ob_rd4),
    .egress_en(egress_en), .m_axis(m_axis4), .m_axis_tready(m_axis_tready),
    .frame_cnt(frame_cnt4), .beat_cnt(beat_cnt4), .egress_busy(egress_busy4)
  );

  task automatic check_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input axi4s_dp_bus_t obs, input axi4s_dp_bus_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic axi4s_dp_bus_t mk(input int idx, input logic last);
    axi4s_dp_bus_t w;
    w.tvalid = 1'($urandom);
    w.tlast  = last;
    w.tid    = 8'(idx);
    w.tstrb  = 8'($urandom);
    w.tuser  = 8'($urandom);
    w.tdata  = {$urandom, $urandom};
    return w;
  endfunction

  // Parser FIFO model: head word is visible whenever the queue is non-empty.
  task automatic drive();
    tlvp_ob_empty = (src_q.size() == 0);
    tlvp_ob       = (src_q.size() == 0) ? '0 : src_q[0];
  endtask

  task automatic load(input axi4s_dp_bus_t w);
    axi4s_dp_bus_t e;
    src_q.push_back(w);
    e = w;
    e.tvalid = 1'b1;
    exp_q.push_back(e);
    drive();
  endtask

  // One clock: sample mid-cycle, update models just after the edge.
  task automatic cycle();
    logic rd_s, acc_s;
    axi4s_dp_bus_t obs;
    @(negedge clk);
    rd_s  = tlvp_ob_rd;
    acc_s = m_axis.tvalid && m_axis_tready;
    obs   = m_axis;
    if ((pops - accepts) > 0 && !m_axis.tvalid) drops++;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      pops++;
      if (first_pop < 0) first_pop = cyc;
    end
    if (acc_s) begin
      if (accepts > 0 && last_acc != cyc - 1) gaps++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      accepts++;
      if (exp_q.size() == 0) check_n("unexpected_beat", 32'd1, 32'd0);
      else check_w("beat_data", obs, exp_q.pop_front());
    end
    drive();
    #1;
  endtask

  task automatic run_drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() > 0; n++) cycle();
    check_n("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_q.delete();
    exp_q.delete();
    egress_en = 1'b1;
    m_axis_tready = 1'b0;
    pops = 0; accepts = 0; first_pop = -1; first_acc = -1; last_acc = -1;
    gaps = 0; drops = 0; cyc = 0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    axi4s_dp_bus_t ref0;
    int pops_at;

    rst_n = 1'b0;
    tlvp_ob_aempty = 1'b0;
    egress_en = 1'b1;
    m_axis_tready = 1'b0;
    tlvp_ob_empty = 1'b1;
    tlvp_ob = '0;
    #12;
    check_n("rst_tvalid", 32'(m_axis.tvalid), 0);
    check_w("rst_fields", m_axis, '0);
    check_n("rst_busy", 32'(egress_busy), 0);
    check_n("rst_frame", frame_cnt, 0);
    check_n("rst_beat", beat_cnt, 0);
    check_n("rst_rd_empty", 32'(tlvp_ob_rd), 0);
    load(mk(0, 1'b0));
    #1;
    check_n("rst_rd_follows", 32'(tlvp_ob_rd), 1);
    egress_en = 1'b0;
    #1;
    check_n("rst_rd_en0", 32'(tlvp_ob_rd), 0);

    // Back-to-back streaming, two 4-beat frames.
    do_reset();
    for (int i = 0; i < 8; i++) load(mk(i, (i == 3) || (i == 7)));
    m_axis_tready = 1'b1;
    run_drain(40);
    check_n("b2b_latency", first_acc, first_pop + 1);
    check_n("b2b_accepts", accepts, 8);
    check_n("b2b_gaps", gaps, 0);
    check_n("b2b_beat", beat_cnt, 8);
    check_n("b2b_frame", frame_cnt, 2);
    check_n("b2b_busy", 32'(egress_busy), 0);

    // Backpressure: 3 words, tready low for 5 cycles.
    do_reset();
    for (int i = 0; i < 3; i++) load(mk(10 + i, i == 2));
    ref0 = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_w("bp_hold", m_axis, ref0);
    end
    check_n("bp_pops", pops, 2);
    check_n("bp_rd_full", 32'(tlvp_ob_rd), 0);
    m_axis_tready = 1'b1;
    run_drain(20);
    check_n("bp_pops_total", pops, 3);
    check_n("bp_accepts", accepts, 3);

    // Alternating tready over 10 words.
    do_reset();
    for (int i = 0; i < 10; i++) load(mk(20 + i, i == 9));
    m_axis_tready = 1'b1;
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
      cycle();
      m_axis_tready = ~m_axis_tready;
    end
    check_n("alt_drain", exp_q.size(), 0);
    check_n("alt_drops", drops, 0);
    check_n("alt_beat", beat_cnt, 10);
    check_n("alt_frame", frame_cnt, 1);

    // egress_en dropped after beat 2 of a 5-beat frame.
    do_reset();
    for (int i = 0; i < 5; i++) load(mk(30 + i, i == 4));
    m_axis_tready = 1'b1;
    for (int n = 0; n < 20 && accepts < 2; n++) cycle();
    egress_en = 1'b0;
    pops_at = pops;
    repeat (6) cycle();
    check_n("en_no_pops", pops, pops_at);
    check_n("en_drain_le2", 32'(accepts <= 4), 1);
    check_n("en_busy", 32'(egress_busy), 1);
    check_n("en_rd", 32'(tlvp_ob_rd), 0);
    check_n("en_frame_hold", frame_cnt, 0);
    egress_en = 1'b1;
    run_drain(20);
    check_n("en_frame", frame_cnt, 1);
    check_n("en_beat", beat_cnt, 5);
    check_n("en_busy_end", 32'(egress_busy), 0);

    // Reset mid-frame with the buffer full.
    do_reset();
    for (int i = 0; i < 4; i++) load(mk(40 + i, 1'b0));
    cycle();
    cycle();
    m_axis_tready = 1'b1;
    cycle();
    m_axis_tready = 1'b0;
    cycle();
    check_n("mrst_pre_beat", beat_cnt, 1);
    check_n("mrst_pre_busy", 32'(egress_busy), 1);
    check_n("mrst_pre_pops", pops, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_n("mrst_tvalid", 32'(m_axis.tvalid), 0);
    check_n("mrst_beat", beat_cnt, 0);
    check_n("mrst_frame", frame_cnt, 0);
    check_n("mrst_busy", 32'(egress_busy), 0);
    do_reset();
    load(mk(50, 1'b1));
    m_axis_tready = 1'b1;
    run_drain(10);
    check_n("mrst_new_frame", frame_cnt, 1);
    check_n("mrst_new_beat", beat_cnt, 1);

    // Counter wrap on the 4-bit instance.
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 17; i++) load(mk(60 + i, 1'b1));
    run_drain(60);
    check_n("wrap_frame4", 32'(frame_cnt4), 1);
    check_n("wrap_beat4", 32'(beat_cnt4), 1);
    check_n("wrap_frame32", frame_cnt, 17);
    check_n("wrap_beat32", beat_cnt, 17);
    check_n("wrap_busy4", 32'(egress_busy4), 0);
    check_n("wrap_rd4", 32'(tlvp_ob_rd4), 32'(tlvp_ob_rd));
    check_w("wrap_axis4", m_axis4, m_axis);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
